// File: rtl/noc_pkg.sv
// Link flow-control protocol selectors shared by the NoC blocks.
package noc;
    localparam int kFlowControlAckNack     = 0;
    localparam int kFlowControlCreditBased = 1;
endpackage

// File: rtl/noc_sync_fifo.sv
// Circular synchronous FIFO for any Depth >= 2, not only powers of two.
// The caller must not push when full unless it pops in the same cycle.
module noc_sync_fifo #(
    parameter int Width = 34,
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);
    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rdata = mem[rd_ptr];
    assign full  = (count == CntW'(Depth));
    assign empty = (count == '0);

    // Storage array; contents are irrelevant while the FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap at Depth-1; count moves only when exactly one of push/pop happens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/noc_link_buffer.sv
// Single-link input buffer: FIFO, registered output stage, and either
// ack/nack stop or credit-based flow control selected at elaboration.
module noc_link_buffer
    import noc::*;
#(
    parameter int FlowControl   = kFlowControlCreditBased,
    parameter int Width         = 34,
    parameter int Depth         = 4,
    parameter int StopThreshold = 2,
    parameter int InitCredits   = 4,
    localparam int OccW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] data_in,
    input  logic             data_void_in,
    output logic             stop_out,
    output logic [Width-1:0] data_out,
    output logic             data_void_out,
    input  logic             stop_in,
    output logic [OccW-1:0]  occupancy,
    output logic             overflow_err,
    output logic             credit_err
);
    logic             fifo_full, fifo_empty;
    logic [Width-1:0] head;
    logic             send_ok, pop, wr_ok;

    // Pop is decided on pre-edge state, so a full FIFO that pops can also accept a write.
    assign pop   = !fifo_empty && send_ok;
    assign wr_ok = !data_void_in && (!fifo_full || pop);

    noc_sync_fifo #(.Width(Width), .Depth(Depth)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_ok),
        .wdata (data_in),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // Output stage: load head on pop, otherwise hold data and mark void.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out      <= '0;
            data_void_out <= 1'b1;
        end else begin
            data_void_out <= !pop;
            if (pop) data_out <= head;
        end
    end

    // Sticky overflow: a flit arrived with no room and no simultaneous pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      overflow_err <= 1'b0;
        else if (!data_void_in && fifo_full && !pop)   overflow_err <= 1'b1;
    end

    if (FlowControl == kFlowControlCreditBased) begin : g_credit
        localparam int CrW = $clog2(InitCredits + 1);
        logic [CrW-1:0] credit_cnt;

        assign send_ok = (credit_cnt != '0);

        // Downstream credits: pop spends one, stop_in pulse returns one; saturate at the ceiling.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                credit_cnt <= CrW'(InitCredits);
                credit_err <= 1'b0;
                stop_out   <= 1'b0;
            end else begin
                stop_out <= pop;
                case ({pop, stop_in})
                    2'b10: credit_cnt <= credit_cnt - 1'b1;
                    2'b01: begin
                        if (credit_cnt == CrW'(InitCredits)) credit_err <= 1'b1;
                        else                                 credit_cnt <= credit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end else begin : g_acknack
        logic [OccW-1:0] next_occ;

        assign send_ok    = !stop_in;
        assign credit_err = 1'b0;
        assign next_occ   = occupancy + {{(OccW-1){1'b0}}, wr_ok} - {{(OccW-1){1'b0}}, pop};

        // Registered stop: raise once free space after this edge falls to the threshold.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) stop_out <= 1'b0;
            else      stop_out <= (Depth - int'(next_occ)) <= StopThreshold;
        end
    end
endmodule

// File: tb/tb_noc_link_buffer.sv
// Directed bench: credit DUT (Depth 4), ack/nack DUT (Depth 4), ack/nack DUT (Depth 3).
module tb_noc_link_buffer;
    import noc::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Credit DUT
    logic [33:0] din_cr = '0, dout_cr;
    logic        void_cr = 1'b1, sin_cr = 1'b0, sout_cr, dvo_cr, ovf_cr, cerr_cr;
    logic [2:0]  occ_cr;
    // Ack/nack DUT, Depth 4
    logic [33:0] din_an = '0, dout_an;
    logic        void_an = 1'b1, sin_an = 1'b0, sout_an, dvo_an, ovf_an, cerr_an;
    logic [2:0]  occ_an;
    // Ack/nack DUT, Depth 3
    logic [15:0] din_w3 = '0, dout_w3;
    logic        void_w3 = 1'b1, sin_w3 = 1'b0, sout_w3, dvo_w3, ovf_w3, cerr_w3;
    logic [1:0]  occ_w3;

    noc_link_buffer #(.FlowControl(kFlowControlCreditBased), .Width(34), .Depth(4), .InitCredits(4)) u_cr (
        .clk(clk), .rst(rst), .data_in(din_cr), .data_void_in(void_cr), .stop_out(sout_cr),
        .data_out(dout_cr), .data_void_out(dvo_cr), .stop_in(sin_cr), .occupancy(occ_cr),
        .overflow_err(ovf_cr), .credit_err(cerr_cr));

    noc_link_buffer #(.FlowControl(kFlowControlAckNack), .Width(34), .Depth(4), .StopThreshold(2)) u_an (
        .clk(clk), .rst(rst), .data_in(din_an), .data_void_in(void_an), .stop_out(sout_an),
        .data_out(dout_an), .data_void_out(dvo_an), .stop_in(sin_an), .occupancy(occ_an),
        .overflow_err(ovf_an), .credit_err(cerr_an));

    noc_link_buffer #(.FlowControl(kFlowControlAckNack), .Width(16), .Depth(3), .StopThreshold(2)) u_w3 (
        .clk(clk), .rst(rst), .data_in(din_w3), .data_void_in(void_w3), .stop_out(sout_w3),
        .data_out(dout_w3), .data_void_out(dvo_w3), .stop_in(sin_w3), .occupancy(occ_w3),
        .overflow_err(ovf_w3), .credit_err(cerr_w3));

    // Output logs, sampled on the falling edge
    logic [33:0] q_cr[$];
    logic [33:0] q_an[$];
    logic [15:0] q_w3[$];
    int          cr_stops = 0;

    always @(negedge clk) begin
        if (!dvo_cr) q_cr.push_back(dout_cr);
        if (!dvo_an) q_an.push_back(dout_an);
        if (!dvo_w3) q_w3.push_back(dout_w3);
        if (sout_cr) cr_stops++;
    end

    function automatic logic [33:0] flit(input int k);
        return 34'(32'hA5A5_0000 + k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        void_cr = 1'b1; sin_cr = 1'b0;
        void_an = 1'b1; sin_an = 1'b0;
        void_w3 = 1'b1; sin_w3 = 1'b0;
        rst = 1'b0;
        step();
        step();
        q_cr.delete(); q_an.delete(); q_w3.delete();
        cr_stops = 0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        checks++;
        if (dout_cr !== '0 || dvo_cr !== 1'b1 || sout_cr !== 1'b0 || occ_cr !== 3'd0 ||
            ovf_cr !== 1'b0 || cerr_cr !== 1'b0 || u_cr.g_credit.credit_cnt !== 3'd4) begin
            errors++;
            $display("FAIL reset_cr: data=%h void=%b stop=%b occ=%0d ovf=%b cerr=%b cnt=%0d",
                     dout_cr, dvo_cr, sout_cr, occ_cr, ovf_cr, cerr_cr, u_cr.g_credit.credit_cnt);
        end
        checks++;
        if (dout_an !== '0 || dvo_an !== 1'b1 || sout_an !== 1'b0 || occ_an !== 3'd0 ||
            ovf_an !== 1'b0 || cerr_an !== 1'b0) begin
            errors++;
            $display("FAIL reset_an: data=%h void=%b stop=%b occ=%0d ovf=%b", dout_an, dvo_an, sout_an, occ_an, ovf_an);
        end
        checks++;
        if (dvo_w3 !== 1'b1 || occ_w3 !== 2'd0 || sout_w3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w3: void=%b occ=%0d stop=%b", dvo_w3, occ_w3, sout_w3);
        end
    endtask

    // Six back-to-back flits into 4 credits; each credit pulse releases one more.
    task automatic test_credit_flow();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            void_cr = (k >= 6);
            din_cr  = flit(k);
            step();
            checks++;
            if (k >= 1 && k <= 4) begin
                if (dvo_cr !== 1'b0 || dout_cr !== flit(k - 1)) begin
                    errors++;
                    $display("FAIL credit_out_c%0d: void=%b data=%h want valid %h", k, dvo_cr, dout_cr, flit(k - 1));
                end
            end else if (dvo_cr !== 1'b1) begin
                errors++;
                $display("FAIL credit_void_c%0d: void=%b want 1", k, dvo_cr);
            end
        end
        checks++;
        if (cr_stops != 4 || q_cr.size() != 4) begin
            errors++;
            $display("FAIL credit_first4: stops=%0d outs=%0d want 4/4", cr_stops, q_cr.size());
        end
        for (int p = 0; p < 2; p++) begin
            sin_cr = 1'b1;
            step();
            sin_cr = 1'b0;
            repeat (5) step();
            checks++;
            if (q_cr.size() != 5 + p || q_cr[q_cr.size() - 1] !== flit(4 + p) || cr_stops != 5 + p) begin
                errors++;
                $display("FAIL credit_pulse%0d: outs=%0d last=%h stops=%0d want %0d/%h/%0d",
                         p, q_cr.size(), q_cr[q_cr.size() - 1], cr_stops, 5 + p, flit(4 + p), 5 + p);
            end
        end
    endtask

    // Downstream stopped; upstream reacts to stop_out with one cycle of link delay each way.
    task automatic test_acknack_stop();
        logic hist[64];
        int   sent = 0;
        int   peak = 0;
        logic snd;
        do_reset();
        sin_an = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) sin_an = 1'b0;
            hist[c] = sout_an;
            snd = (sent < 6) && (c < 2 || hist[c - 2] == 1'b0);
            void_an = !snd;
            din_an  = flit(100 + sent);
            if (snd) sent++;
            step();
            if (int'(occ_an) > peak) peak = int'(occ_an);
            if (c == 0) begin
                checks++;
                if (sout_an !== 1'b0) begin errors++; $display("FAIL an_stop_after1: got %b want 0", sout_an); end
            end
            if (c == 1) begin
                checks++;
                if (sout_an !== 1'b1) begin errors++; $display("FAIL an_stop_after2: got %b want 1", sout_an); end
            end
        end
        void_an = 1'b1;
        checks++;
        if (peak != 4 || ovf_an !== 1'b0) begin
            errors++;
            $display("FAIL an_peak: peak=%0d ovf=%b want 4/0", peak, ovf_an);
        end
        checks++;
        if (q_an.size() != 6) begin
            errors++;
            $display("FAIL an_count: got %0d want 6", q_an.size());
        end else begin
            for (int i = 0; i < 6; i++)
                if (q_an[i] !== flit(100 + i)) begin
                    errors++;
                    $display("FAIL an_order%0d: got %h want %h", i, q_an[i], flit(100 + i));
                end
        end
    endtask

    // Full FIFO: write+pop accepted, write without pop dropped.
    task automatic test_full_boundary();
        do_reset();
        sin_an = 1'b1;
        for (int k = 0; k < 4; k++) begin
            void_an = 1'b0; din_an = flit(200 + k); step();
        end
        checks++;
        if (occ_an !== 3'd4) begin errors++; $display("FAIL full_fill: occ=%0d want 4", occ_an); end
        sin_an = 1'b0; din_an = flit(204);
        step();
        checks++;
        if (occ_an !== 3'd4 || ovf_an !== 1'b0 || dvo_an !== 1'b0 || dout_an !== flit(200)) begin
            errors++;
            $display("FAIL full_wr_pop: occ=%0d ovf=%b void=%b data=%h want 4/0/0/%h", occ_an, ovf_an, dvo_an, dout_an, flit(200));
        end
        sin_an = 1'b1; din_an = flit(205);
        step();
        checks++;
        if (occ_an !== 3'd4 || ovf_an !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: occ=%0d ovf=%b want 4/1", occ_an, ovf_an);
        end
        void_an = 1'b1; sin_an = 1'b0;
        repeat (8) step();
        checks++;
        if (q_an.size() != 5) begin
            errors++;
            $display("FAIL full_seq_len: got %0d want 5", q_an.size());
        end else begin
            for (int i = 0; i < 5; i++)
                if (q_an[i] !== flit(200 + i)) begin
                    errors++;
                    $display("FAIL full_seq%0d: got %h want %h", i, q_an[i], flit(200 + i));
                end
        end
        checks++;
        if (ovf_an !== 1'b1) begin errors++; $display("FAIL full_sticky: ovf=%b want 1", ovf_an); end
    endtask

    // Credit counter saturation and simultaneous pop + credit pulse.
    task automatic test_credit_counter();
        do_reset();
        sin_cr = 1'b1;
        step();
        sin_cr = 1'b0;
        checks++;
        if (cerr_cr !== 1'b1 || u_cr.g_credit.credit_cnt !== 3'd4) begin
            errors++;
            $display("FAIL cnt_sat: cerr=%b cnt=%0d want 1/4", cerr_cr, u_cr.g_credit.credit_cnt);
        end
        void_cr = 1'b0; din_cr = flit(300);
        step();
        void_cr = 1'b1; sin_cr = 1'b1;
        step();
        sin_cr = 1'b0;
        checks++;
        if (u_cr.g_credit.credit_cnt !== 3'd4 || dvo_cr !== 1'b0 || dout_cr !== flit(300) || cerr_cr !== 1'b1) begin
            errors++;
            $display("FAIL cnt_pop_pulse: cnt=%0d void=%b data=%h cerr=%b want 4/0/%h/1",
                     u_cr.g_credit.credit_cnt, dvo_cr, dout_cr, flit(300), cerr_cr);
        end
        for (int k = 1; k <= 5; k++) begin
            void_cr = 1'b0; din_cr = flit(300 + k); step();
        end
        void_cr = 1'b1;
        repeat (10) step();
        checks++;
        if (q_cr.size() != 5) begin
            errors++;
            $display("FAIL cnt_release: outs=%0d want 5", q_cr.size());
        end
    endtask

    // Depth 3 wrap-around with patterned voids and downstream stops.
    task automatic test_wrap();
        logic [31:0] vpat = 32'hB53C_96E1;
        logic [31:0] spat = 32'h4A21_8813;
        logic        hist[400];
        int          sent = 0;
        logic        snd;
        do_reset();
        for (int c = 0; c < 400 && q_w3.size() < 20; c++) begin
            hist[c] = sout_w3;
            snd = (sent < 20) && !vpat[c % 32] && (c < 2 || hist[c - 2] == 1'b0);
            void_w3 = !snd;
            din_w3  = 16'(16'h5A00 + sent);
            sin_w3  = spat[c % 32];
            if (snd) sent++;
            step();
        end
        void_w3 = 1'b1; sin_w3 = 1'b0;
        step();
        checks++;
        if (ovf_w3 !== 1'b0 || q_w3.size() != 20) begin
            errors++;
            $display("FAIL wrap_count: ovf=%b outs=%0d want 0/20", ovf_w3, q_w3.size());
        end else begin
            for (int i = 0; i < 20; i++)
                if (q_w3[i] !== 16'(16'h5A00 + i)) begin
                    errors++;
                    $display("FAIL wrap_order%0d: got %h want %h", i, q_w3[i], 16'(16'h5A00 + i));
                end
        end
    endtask

    // Reset mid-stream with flits queued, then fresh traffic.
    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            void_cr = 1'b0; din_cr = flit(400 + k); step();
        end
        void_cr = 1'b1;
        checks++;
        if (occ_cr !== 3'd3) begin errors++; $display("FAIL mid_queued: occ=%0d want 3", occ_cr); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dvo_cr !== 1'b1 || occ_cr !== 3'd0 || u_cr.g_credit.credit_cnt !== 3'd4 || sout_cr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: void=%b occ=%0d cnt=%0d stop=%b want 1/0/4/0",
                     dvo_cr, occ_cr, u_cr.g_credit.credit_cnt, sout_cr);
        end
        step();
        q_cr.delete();
        rst = 1'b1;
        void_cr = 1'b0; din_cr = flit(500);
        step();
        checks++;
        if (dvo_cr !== 1'b1) begin errors++; $display("FAIL mid_lat1: void=%b want 1", dvo_cr); end
        din_cr = flit(501);
        step();
        void_cr = 1'b1;
        checks++;
        if (dvo_cr !== 1'b0 || dout_cr !== flit(500)) begin
            errors++;
            $display("FAIL mid_lat2: void=%b data=%h want 0/%h", dvo_cr, dout_cr, flit(500));
        end
        repeat (6) step();
        checks++;
        if (q_cr.size() != 2 || q_cr[0] !== flit(500) || q_cr[1] !== flit(501)) begin
            errors++;
            $display("FAIL mid_fresh: outs=%0d want 2 new flits only", q_cr.size());
        end
    endtask

    initial begin
        test_reset();
        test_credit_flow();
        test_acknack_stop();
        test_full_boundary();
        test_credit_counter();
        test_wrap();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running want done");
        $fatal(1);
    end
endmodule
